// File: rtl/uart_alu_frame_if.sv
// uart_alu_frame_if
//   Frames ALU operations over a UART FIFO pair. A frame is one opcode word,
//   then OP_BYTES words of operand A and then OP_BYTES words of operand B.
//   Each operand arrives least-significant word first. After the last B word
//   the operands are committed to the ALU. The result is sampled ALU_LAT
//   cycles later and is returned as OP_BYTES words, least-significant first.
//   A frame that stalls for TIMEOUT empty cycles is dropped.
//
// Ports
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_rx_empty, i_r_data       RX FIFO status and head word (first-word fall-through)
//   o_rd_uart                  RX FIFO pop strobe
//   i_tx_full                  TX FIFO full
//   o_w_data, o_wr_uart        TX FIFO word and push strobe
//   i_result_data              ALU result
//   o_op_a, o_op_b, o_op_code  ALU operands and opcode (held between commits)
//   o_valid                    one-cycle pulse after operands are committed
//   o_busy                     high whenever the FSM is outside IDLE
//   o_timeout                  one-cycle pulse after a frame is aborted
//
// state    | meaning
// IDLE     | waiting for an opcode word
// RX_A     | collecting operand A words
// RX_B     | collecting operand B words; the last word commits the operands
// WAIT_ALU | ALU_LAT cycles of ALU latency, then the result is latched
// TX       | pushing result words into the TX FIFO
module uart_alu_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_BYTES   = 2,
  parameter int OPCODE_SZ  = 6,
  parameter int ALU_LAT    = 1,
  parameter int TIMEOUT    = 1000,
  localparam int OP_SZ     = DATA_WIDTH * OP_BYTES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_empty,
  input  logic [DATA_WIDTH-1:0] i_r_data,
  output logic                  o_rd_uart,
  input  logic                  i_tx_full,
  output logic [DATA_WIDTH-1:0] o_w_data,
  output logic                  o_wr_uart,
  input  logic [OP_SZ-1:0]      i_result_data,
  output logic [OP_SZ-1:0]      o_op_a,
  output logic [OP_SZ-1:0]      o_op_b,
  output logic [OPCODE_SZ-1:0]  o_op_code,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int CNT_W  = $clog2(OP_BYTES + 1);
  localparam int LAT_W  = $clog2(ALU_LAT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_A     = 3'd1,
    S_RX_B     = 3'd2,
    S_WAIT_ALU = 3'd3,
    S_TX       = 3'd4
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       word_cnt;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [OPCODE_SZ-1:0]   sh_op;
  logic [OP_SZ-1:0]       sh_a;
  logic [OP_SZ-1:0]       sh_b;
  logic [OP_SZ-1:0]       res_sr;
  logic [OP_SZ-1:0]       a_next;
  logic [OP_SZ-1:0]       b_next;
  logic                   rx_phase;
  logic                   pop;
  logic                   push;
  logic                   last_word;
  logic                   idle_expired;

  assign rx_phase     = (state == S_IDLE) || (state == S_RX_A) || (state == S_RX_B);
  assign pop          = !i_reset && rx_phase && !i_rx_empty;
  assign push         = !i_reset && (state == S_TX) && !i_tx_full;
  assign last_word    = (word_cnt == CNT_W'(OP_BYTES - 1));
  assign idle_expired = (idle_cnt == IDLE_W'(TIMEOUT - 1));

  assign o_rd_uart = pop;
  assign o_wr_uart = push;
  assign o_w_data  = (state == S_TX) ? res_sr[DATA_WIDTH-1:0] : '0;
  assign o_busy    = (state != S_IDLE);

  // Shadow operands with the word being popped this cycle merged in, so the
  // last B word can be committed on the same edge that captures it.
  always_comb begin
    a_next = sh_a;
    b_next = sh_b;
    a_next[int'(word_cnt)*DATA_WIDTH +: DATA_WIDTH] = i_r_data;
    b_next[int'(word_cnt)*DATA_WIDTH +: DATA_WIDTH] = i_r_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      idle_cnt  <= '0;
      lat_cnt   <= '0;
      sh_op     <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      res_sr    <= '0;
      o_op_a    <= '0;
      o_op_b    <= '0;
      o_op_code <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          word_cnt <= '0;
          idle_cnt <= '0;
          if (pop) begin
            sh_op <= i_r_data[OPCODE_SZ-1:0];
            state <= S_RX_A;
          end
        end

        S_RX_A, S_RX_B: begin
          if (pop) begin
            // A pop always clears the idle counter, even on the threshold cycle.
            idle_cnt <= '0;
            if (state == S_RX_A) sh_a <= a_next;
            else                 sh_b <= b_next;
            if (last_word) begin
              word_cnt <= '0;
              if (state == S_RX_A) begin
                state <= S_RX_B;
              end else begin
                o_op_code <= sh_op;
                o_op_a    <= sh_a;
                o_op_b    <= b_next;
                o_valid   <= 1'b1;
                lat_cnt   <= LAT_W'(ALU_LAT - 1);
                state     <= S_WAIT_ALU;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (idle_expired) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            idle_cnt  <= '0;
            sh_op     <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            o_timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_WAIT_ALU: begin
          if (lat_cnt == '0) begin
            res_sr   <= i_result_data;
            word_cnt <= '0;
            state    <= S_TX;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        S_TX: begin
          if (push) begin
            res_sr <= res_sr >> DATA_WIDTH;
            if (last_word) begin
              word_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          word_cnt <= '0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_frame_if.sv
// Testbench for uart_alu_frame_if (DATA_WIDTH=8, OP_BYTES=2, ALU_LAT=1, TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled mid-cycle.
module tb_uart_alu_frame_if;

  localparam int DW = 8;
  localparam int OB = 2;
  localparam int OS = DW * OB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic          rd_uart;
  logic          tx_full = 1'b0;
  logic [DW-1:0] w_data;
  logic          wr_uart;
  logic [OS-1:0] result;
  logic [OS-1:0] op_a;
  logic [OS-1:0] op_b;
  logic [5:0]    op_code;
  logic          valid;
  logic          busy;
  logic          timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pop_cnt = 0;
  int rd_while_empty = 0;
  int valid_cnt = 0;
  int to_cnt = 0;
  logic [DW-1:0] push_q[$];
  int            push_cyc[$];

  logic [5:0]    last_op = '0;
  logic [OS-1:0] last_a  = '0;
  logic [OS-1:0] last_b  = '0;

  uart_alu_frame_if #(
    .DATA_WIDTH(DW), .OP_BYTES(OB), .OPCODE_SZ(6), .ALU_LAT(1), .TIMEOUT(16)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_empty(rx_empty), .i_r_data(r_data),
    .o_rd_uart(rd_uart), .i_tx_full(tx_full), .o_w_data(w_data), .o_wr_uart(wr_uart),
    .i_result_data(result), .o_op_a(op_a), .o_op_b(op_b), .o_op_code(op_code),
    .o_valid(valid), .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: opcode bit 1 selects XOR, otherwise add.
  assign result = op_code[1] ? (op_a ^ op_b) : (op_a + op_b);

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (rd_uart) pop_cnt++;
      if (rd_uart && rx_empty) rd_while_empty++;
      if (wr_uart) begin
        push_q.push_back(w_data);
        push_cyc.push_back(cyc);
      end
      if (valid) valid_cnt++;
      if (timeout) to_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rx_empty = 1'b1;
    r_data   = 8'($urandom);
  endtask

  task automatic put_word(input logic [DW-1:0] w);
    @(negedge clk);
    rx_empty = 1'b0;
    r_data   = w;
  endtask

  function automatic logic [OS-1:0] model_alu(input logic [5:0] op, input logic [OS-1:0] a,
                                               input logic [OS-1:0] b);
    if (op[1]) return a ^ b;
    return a + b;
  endfunction

  task automatic send_frame(input logic [7:0] op8, input logic [OS-1:0] a,
                            input logic [OS-1:0] b, input int gap);
    logic [7:0] words[5];
    words[0] = op8;
    words[1] = a[7:0];
    words[2] = a[15:8];
    words[3] = b[7:0];
    words[4] = b[15:8];
    for (int i = 0; i < 5; i++) begin
      repeat (gap) idle_cycle();
      put_word(words[i]);
      if (i == 3) begin
        #1;
        chk("hold_op_a", 32'(op_a), 32'(last_a));
        chk("hold_op_code", 32'(op_code), 32'(last_op));
      end
    end
    idle_cycle();
  endtask

  // Called just after the falling edge that follows the last word of a frame.
  task automatic check_frame(input logic [7:0] op8, input logic [OS-1:0] a,
                             input logic [OS-1:0] b, input int full_cycles);
    logic [5:0]    eop;
    logic [OS-1:0] eres;
    int            v0;
    int            n;
    eop  = op8[5:0];
    eres = model_alu(eop, a, b);
    v0   = valid_cnt;
    #1;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("valid_seen", 32'(valid), 32'd1);
    chk("op_code", 32'(op_code), 32'(eop));
    chk("op_a", 32'(op_a), 32'(a));
    chk("op_b", 32'(op_b), 32'(b));
    for (int i = 0; i < full_cycles; i++) begin
      @(negedge clk);
      #1;
      chk("bp_w_data", 32'(w_data), 32'(eres[7:0]));
      chk("bp_no_push", 32'(wr_uart), 32'd0);
    end
    @(negedge clk);
    tx_full = 1'b0;
    #1;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("busy_fall", 32'(busy), 32'd0);
    chk("w_data_idle", 32'(w_data), 32'd0);
    #3;
    chk("valid_pulses", 32'(valid_cnt - v0), 32'd1);
    chk("push_count", 32'(push_q.size()), 32'd2);
    if (push_q.size() == 2) begin
      chk("tx_word0", 32'(push_q[0]), 32'(eres[7:0]));
      chk("tx_word1", 32'(push_q[1]), 32'(eres[15:8]));
      chk("tx_back_to_back", 32'(push_cyc[1] - push_cyc[0]), 32'd1);
    end
    last_op = eop;
    last_a  = a;
    last_b  = b;
  endtask

  task automatic run_frame(input logic [7:0] op8, input logic [OS-1:0] a,
                           input logic [OS-1:0] b, input int gap, input int full_cycles);
    push_q.delete();
    push_cyc.delete();
    tx_full = (full_cycles > 0);
    send_frame(op8, a, b, gap);
    check_frame(op8, a, b, full_cycles);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int to0;
    int p0;
    int v0;

    // Reset with both FIFOs offering traffic.
    #1 reset = 1'b1;
    rx_empty = 1'b0;
    tx_full  = 1'b0;
    r_data   = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_uart", 32'(rd_uart), 32'd0);
    chk("rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_op_code", 32'(op_code), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    @(negedge clk);
    rx_empty = 1'b1;
    reset    = 1'b0;
    idle_cycle();

    // Basic frame.
    run_frame(8'hE5, 16'h1234, 16'h0011, 0, 0);
    chk("basic_op_code_lit", 32'(op_code), 32'h25);

    // Gapped frame: five pops, never while empty.
    p0 = pop_cnt;
    run_frame(8'hE5, 16'h1234, 16'h0011, 3, 0);
    chk("gapped_pops", 32'(pop_cnt - p0), 32'd5);

    // TX backpressure for 5 cycles at TX entry.
    run_frame(8'hE5, 16'h1234, 16'h0011, 0, 5);

    // Timeout after 16 empty cycles.
    to0 = to_cnt;
    v0  = valid_cnt;
    put_word(8'h01);
    put_word(8'hAA);
    for (int i = 0; i < 16; i++) begin
      idle_cycle();
      #1;
      chk("to_not_yet", 32'(timeout), 32'd0);
    end
    idle_cycle();
    #1;
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_op_a_kept", 32'(op_a), 32'(last_a));
    chk("to_op_b_kept", 32'(op_b), 32'(last_b));
    chk("to_op_code_kept", 32'(op_code), 32'(last_op));
    idle_cycle();
    #1;
    chk("to_one_cycle", 32'(timeout), 32'd0);
    chk("to_no_valid", 32'(valid_cnt - v0), 32'd0);
    run_frame(8'h3C, 16'hBEEF, 16'h0102, 1, 0);

    // Pop on the threshold cycle: frame continues, no timeout.
    to0 = to_cnt;
    push_q.delete();
    push_cyc.delete();
    put_word(8'h01);
    put_word(8'hAA);
    repeat (15) idle_cycle();
    put_word(8'hBB);
    put_word(8'hCC);
    put_word(8'hDD);
    idle_cycle();
    check_frame(8'h01, 16'hBBAA, 16'hDDCC, 0);
    chk("boundary_no_timeout", 32'(to_cnt - to0), 32'd0);

    // Reset mid-frame after three words.
    v0 = valid_cnt;
    push_q.delete();
    put_word(8'hE5);
    put_word(8'h34);
    put_word(8'h12);
    @(negedge clk);
    rx_empty = 1'b0;
    r_data   = 8'h11;
    reset    = 1'b1;
    #1;
    chk("mid_rst_op_a", 32'(op_a), 32'd0);
    chk("mid_rst_op_b", 32'(op_b), 32'd0);
    chk("mid_rst_op_code", 32'(op_code), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd_uart", 32'(rd_uart), 32'd0);
    @(negedge clk);
    rx_empty = 1'b1;
    reset    = 1'b0;
    repeat (6) idle_cycle();
    #3;
    chk("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("mid_rst_no_push", 32'(push_q.size()), 32'd0);
    last_op = '0;
    last_a  = '0;
    last_b  = '0;
    run_frame(8'hE5, 16'h1234, 16'h0011, 0, 0);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      logic [7:0]    rop;
      logic [OS-1:0] ra;
      logic [OS-1:0] rb;
      rop = 8'($urandom);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      run_frame(rop, ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    chk("rd_while_empty", 32'(rd_while_empty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_frame_if.md
UART_ALU_FRAME_IF -- requirements
Module: uart_alu_frame_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART word width in bits.
REQ-002 SHALL have parameter OP_BYTES, default 2, UART words per operand and per result; OP_SZ = DATA_WIDTH*OP_BYTES.
REQ-003 SHALL have parameter OPCODE_SZ, default 6, opcode width, <= DATA_WIDTH.
REQ-004 SHALL have parameter ALU_LAT, default 1, cycles from operand commit to valid i_result_data, >= 1.
REQ-005 SHALL have parameter TIMEOUT, default 1000, max idle cycles allowed between words inside a frame, >= 2.
REQ-006 SHALL have ports (name, direction, width, meaning):
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_empty  in  1  RX FIFO empty.
- i_r_data  in  DATA_WIDTH  RX FIFO head word, first-word fall-through.
- o_rd_uart  out  1  RX FIFO pop strobe.
- i_tx_full  in  1  TX FIFO full.
- o_w_data  out  DATA_WIDTH  TX word.
- o_wr_uart  out  1  TX FIFO push strobe.
- i_result_data  in  OP_SZ  ALU result.
- o_op_a  out  OP_SZ  ALU operand A.
- o_op_b  out  OP_SZ  ALU operand B.
- o_op_code  out  OPCODE_SZ  ALU opcode.
- o_valid  out  1  one-cycle pulse: new operands committed.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  one-cycle pulse: frame aborted on timeout.

Function
REQ-007 SHALL implement states IDLE, RX_A, RX_B, WAIT_ALU, TX.
REQ-008 Frame format SHALL be 1 opcode word, then OP_BYTES words of A, then OP_BYTES words of B, each operand least-significant word first.
REQ-009 In IDLE, RX_A and RX_B, o_rd_uart SHALL equal ~i_rx_empty, combinationally.
REQ-010 Each word SHALL be captured on the edge where o_rd_uart=1.
REQ-011 No pop SHALL occur in WAIT_ALU or TX.
REQ-012 IDLE with a pop SHALL capture i_r_data[OPCODE_SZ-1:0] into a shadow opcode register, then go to RX_A.
REQ-013 RX_A and RX_B SHALL load words into shadow A/B registers at slot index k (bits [k*DATA_WIDTH +: DATA_WIDTH]), k counting 0..OP_BYTES-1.
- After word OP_BYTES-1 of A: go to RX_B.
- After word OP_BYTES-1 of B: go to WAIT_ALU.
REQ-014 On the last B word the edge SHALL commit shadow opcode/A/B to o_op_code/o_op_a/o_op_b, and o_valid SHALL be 1 in the following cycle only.
REQ-015 Outputs o_op_* SHALL hold their values at all other times, including during frame reception.
REQ-016 WAIT_ALU SHALL last exactly ALU_LAT cycles.
- On its last cycle, i_result_data SHALL be loaded into a result shift register.
- The state SHALL then go to TX.
REQ-017 In TX:
- o_w_data SHALL equal the result register's low word.
- o_wr_uart SHALL equal ~i_tx_full, combinationally.
- Each push SHALL shift the register right by DATA_WIDTH.
- After OP_BYTES pushes, the state SHALL go to IDLE.
REQ-018 While i_tx_full=1 in TX, state, word counter and o_w_data SHALL hold.
REQ-019 o_w_data SHALL be 0 outside TX.
REQ-020 An idle counter SHALL clear on every pop and increment each cycle in RX_A/RX_B with i_rx_empty=1.
REQ-021 When the idle counter reaches TIMEOUT:
- The state SHALL go to IDLE and the word counter SHALL clear.
- Shadow registers SHALL be discarded; o_op_* SHALL be unchanged.
- o_timeout SHALL pulse for one cycle.
REQ-022 The timeout counter SHALL be inactive in IDLE, WAIT_ALU and TX.
REQ-023 If a pop and the timeout threshold fall in the same cycle, the pop SHALL win and the counter SHALL clear.
REQ-024 Unused state encodings SHALL go to IDLE.

Reset
REQ-025 While i_reset=1 the block SHALL be in IDLE with all counters, shadow registers and o_op_a/o_op_b/o_op_code/o_w_data = 0.
REQ-026 While i_reset=1, o_valid/o_busy/o_timeout SHALL be 0, and o_rd_uart/o_wr_uart SHALL be 0 regardless of FIFO flags.
REQ-027 Reset mid-frame SHALL abort the frame.
- No o_valid or o_wr_uart SHALL follow.
- The first word after release SHALL be treated as an opcode.

Verification (DATA_WIDTH=8, OP_BYTES=2, ALU_LAT=1, TIMEOUT=16)
REQ-028 Basic frame: words E5,34,12,11,00 back-to-back with i_result_data=1245 -> o_op_code=25, o_op_a=1234, o_op_b=0011, one o_valid pulse; TX pushes 45 then 12; o_busy falls after.
REQ-029 Gapped RX: 3-cycle empty gaps between words -> exactly 5 pops, same outputs as REQ-028, o_rd_uart never 1 while empty.
REQ-030 TX backpressure: i_tx_full=1 for 5 cycles at TX entry -> no push, o_w_data=45 held; after release, pushes 45, 12 on consecutive cycles.
REQ-031 Timeout: send 01,AA then hold empty -> o_timeout pulses 16 empty cycles later, o_op_* unchanged; next frame decodes correctly.
REQ-032 Reset mid-frame: assert i_reset after 3 words -> all outputs 0; following full frame decodes as in REQ-028.
REQ-033 Boundary: pop and TIMEOUT coincide -> no o_timeout, frame continues.
